// File: rtl/elevator_pkg.sv
// Shared types and default constants for the elevator car load supervision path.
package elevator_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_OK,
    ST_OVER_CHK,
    ST_OVER,
    ST_CLR_CHK,
    ST_FAULT
  } load_state_t;

  localparam int DEFAULT_LIMIT_KG    = 600;
  localparam int DEFAULT_HYST_KG     = 40;
  localparam int DEFAULT_TIMEOUT_CYC = 1000;

  typedef struct packed {
    logic weight_limit_exceeded;
    logic door_hold;
    logic buzzer;
    logic sensor_fault;
  } load_out_t;

  localparam load_out_t INIT_OUT = '{weight_limit_exceeded: 1'b0, door_hold: 1'b1,
                                     buzzer: 1'b0, sensor_fault: 1'b0};

  function automatic load_out_t outputs_for(input load_state_t s);
    load_out_t o;
    o = '0;
    case (s)
      ST_INIT, ST_OVER_CHK: o.door_hold = 1'b1;
      ST_OVER, ST_CLR_CHK: begin
        o.weight_limit_exceeded = 1'b1;
        o.door_hold             = 1'b1;
        o.buzzer                = 1'b1;
      end
      ST_FAULT: begin
        o.weight_limit_exceeded = 1'b1;
        o.door_hold             = 1'b1;
        o.sensor_fault          = 1'b1;
      end
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/sample_watchdog.sv
// Saturating count of cycles since the last kick; expired flags the cycle whose
// edge brings the count to TIMEOUT_CYC (and every idle cycle after that).
module sample_watchdog
  import elevator_pkg::*;
#(
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic kick,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] SAT = CW'(TIMEOUT_CYC);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (kick) begin
      count_reg <= '0;
    end else if (count_reg != SAT) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  // A kick in the same cycle always wins over the timeout.
  assign expired = !kick && (count_reg >= SAT - 1'b1);

endmodule

// File: rtl/load_supervisor.sv
// Car overload supervisor: confirms over/clear load with hysteresis, handles
// sensor watchdog faults and issues one departure grant per request.
module load_supervisor
  import elevator_pkg::*;
#(
  parameter int LOAD_W      = 10,
  parameter int LIMIT_KG    = DEFAULT_LIMIT_KG,
  parameter int HYST_KG     = DEFAULT_HYST_KG,
  parameter int CONFIRM_N   = 3,
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic              flip,
  input  logic              flip_reset,
  input  logic [LOAD_W-1:0] load_kg,
  input  logic              load_valid,
  input  logic              door_closed,
  input  logic              depart_req,
  output logic              depart_grant,
  output logic              weight_limit_exceeded,
  output logic              door_hold,
  output logic              buzzer,
  output logic              sensor_fault
);

  localparam int CNT_W = $clog2(CONFIRM_N + 1);
  localparam logic [LOAD_W-1:0] OVER_TH  = LOAD_W'(LIMIT_KG);
  localparam logic [LOAD_W-1:0] CLEAR_TH = LOAD_W'(LIMIT_KG - HYST_KG);
  localparam logic [CNT_W:0]    CONF     = (CNT_W + 1)'(CONFIRM_N);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  load_state_t      state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W:0]   cnt_plus;
  logic             confirm_done;
  logic             armed_reg, armed_next;
  logic             grant_reg, grant_next;
  load_out_t        out_reg, out_next;
  logic             over_sample, clear_sample, expired;

  assign over_sample  = load_valid && (load_kg > OVER_TH);
  assign clear_sample = load_valid && (load_kg <= CLEAR_TH);
  assign cnt_plus     = {1'b0, cnt_reg} + {{CNT_W{1'b0}}, 1'b1};
  assign confirm_done = (cnt_plus >= CONF);

  sample_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_watchdog (
    .clk    (flip),
    .rst_n  (flip_reset),
    .kick   (load_valid),
    .expired(expired)
  );

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (load_valid) begin
      case (state_reg)
        ST_INIT, ST_OK: begin
          cnt_next = '0;
          if (over_sample) begin
            state_next = (CONFIRM_N == 1) ? ST_OVER : ST_OVER_CHK;
            cnt_next   = (CONFIRM_N == 1) ? '0 : CNT_ONE;
          end else begin
            state_next = ST_OK;
          end
        end
        ST_OVER_CHK: begin
          if (!over_sample) begin
            state_next = ST_OK;
            cnt_next   = '0;
          end else if (confirm_done) begin
            state_next = ST_OVER;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_plus[CNT_W-1:0];
          end
        end
        ST_OVER: begin
          if (clear_sample) begin
            state_next = (CONFIRM_N == 1) ? ST_OK : ST_CLR_CHK;
            cnt_next   = (CONFIRM_N == 1) ? '0 : CNT_ONE;
          end
        end
        ST_CLR_CHK: begin
          if (!clear_sample) begin
            state_next = ST_OVER;
            cnt_next   = '0;
          end else if (confirm_done) begin
            state_next = ST_OK;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_plus[CNT_W-1:0];
          end
        end
        ST_FAULT: begin
          // Load is unknown after a fault; it must prove itself clear again.
          state_next = ST_OVER;
          cnt_next   = '0;
        end
        default: begin
          state_next = ST_INIT;
          cnt_next   = '0;
        end
      endcase
    end else if (expired) begin
      state_next = ST_FAULT;
      cnt_next   = '0;
    end
  end

  always_comb begin
    grant_next = (state_reg == ST_OK) && !over_sample && door_closed
                 && depart_req && armed_reg;
    armed_next = armed_reg;
    if (!depart_req) begin
      armed_next = 1'b1;
    end else if (grant_next) begin
      armed_next = 1'b0;
    end
    out_next = outputs_for(state_next);
  end

  always_ff @(posedge flip or negedge flip_reset) begin
    if (!flip_reset) begin
      state_reg <= ST_INIT;
      cnt_reg   <= '0;
      armed_reg <= 1'b0;
      grant_reg <= 1'b0;
      out_reg   <= INIT_OUT;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      armed_reg <= armed_next;
      grant_reg <= grant_next;
      out_reg   <= out_next;
    end
  end

  assign depart_grant          = grant_reg;
  assign weight_limit_exceeded = out_reg.weight_limit_exceeded;
  assign door_hold             = out_reg.door_hold;
  assign buzzer                = out_reg.buzzer;
  assign sensor_fault          = out_reg.sensor_fault;

endmodule

// File: tb/tb_load_supervisor.sv
// Directed plus randomized check of load_supervisor against a behavioural model
// that tracks an overload flag and a qualifying-sample streak.
module tb_load_supervisor;

  localparam int LIMIT   = 600;
  localparam int CLEAR   = 560;
  localparam int CONFN   = 3;
  localparam int TIMEOUT = 20;

  localparam int M_INIT  = 0;
  localparam int M_NORM  = 1;
  localparam int M_OVLD  = 2;
  localparam int M_FAULT = 3;

  logic       flip = 1'b0;
  logic       flip_reset = 1'b0;
  logic [9:0] load_kg = '0;
  logic       load_valid = 1'b0;
  logic       door_closed = 1'b0;
  logic       depart_req = 1'b0;
  logic       depart_grant, weight_limit_exceeded, door_hold, buzzer, sensor_fault;

  int vectors = 0;
  int miscompares = 0;

  int m_mode, m_streak, m_idle;
  bit m_armed, e_grant;

  load_supervisor #(
    .LOAD_W(10), .LIMIT_KG(LIMIT), .HYST_KG(40), .CONFIRM_N(CONFN), .TIMEOUT_CYC(TIMEOUT)
  ) dut (
    .flip(flip), .flip_reset(flip_reset), .load_kg(load_kg), .load_valid(load_valid),
    .door_closed(door_closed), .depart_req(depart_req), .depart_grant(depart_grant),
    .weight_limit_exceeded(weight_limit_exceeded), .door_hold(door_hold),
    .buzzer(buzzer), .sensor_fault(sensor_fault)
  );

  always #5 flip = ~flip;

  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    bit e_wle, e_door, e_buz, e_sf;
    e_wle  = (m_mode == M_OVLD) || (m_mode == M_FAULT);
    e_door = (m_mode != M_NORM) || (m_streak > 0);
    e_buz  = (m_mode == M_OVLD);
    e_sf   = (m_mode == M_FAULT);
    chk({tag, ".grant"}, depart_grant, e_grant);
    chk({tag, ".wle"}, weight_limit_exceeded, e_wle);
    chk({tag, ".door_hold"}, door_hold, e_door);
    chk({tag, ".buzzer"}, buzzer, e_buz);
    chk({tag, ".sensor_fault"}, sensor_fault, e_sf);
  endtask

  task automatic model_reset();
    m_mode = M_INIT; m_streak = 0; m_idle = 0; m_armed = 0; e_grant = 0;
  endtask

  // Model update for one clock edge, from the rules stated in terms of
  // "confirmed overload" and "consecutive qualifying samples".
  task automatic model_edge(input int kg, input bit v, input bit door, input bit req);
    bit over, clr;
    over = v && (kg > LIMIT);
    clr  = v && (kg <= CLEAR);
    e_grant = (m_mode == M_NORM) && (m_streak == 0) && !over && door && req && m_armed;
    if (!req) m_armed = 1;
    else if (e_grant) m_armed = 0;
    if (v) begin
      m_idle = 0;
      if (m_mode == M_FAULT) begin
        m_mode = M_OVLD; m_streak = 0;
      end else if (m_mode == M_OVLD) begin
        m_streak = clr ? m_streak + 1 : 0;
        if (m_streak >= CONFN) begin m_mode = M_NORM; m_streak = 0; end
      end else begin
        m_mode = M_NORM;
        m_streak = over ? m_streak + 1 : 0;
        if (m_streak >= CONFN) begin m_mode = M_OVLD; m_streak = 0; end
      end
    end else begin
      if (m_idle < TIMEOUT) m_idle++;
      if (m_idle == TIMEOUT) begin m_mode = M_FAULT; m_streak = 0; end
    end
  endtask

  task automatic apply(input string tag, input int kg, input bit v, input bit door, input bit req);
    @(negedge flip);
    load_kg = 10'(kg); load_valid = v; door_closed = door; depart_req = req;
    @(posedge flip);
    model_edge(kg, v, door, req);
    #1;
    $display("%s kg=%0d v=%0b door=%0b req=%0b -> grant=%0b wle=%0b hold=%0b buz=%0b sf=%0b",
             tag, kg, v, door, req, depart_grant, weight_limit_exceeded, door_hold, buzzer, sensor_fault);
    check_all(tag);
  endtask

  initial begin
    int kg, n;
    bit v;
    // Reset held: INIT outputs.
    model_reset();
    #12;
    check_all("reset");
    @(negedge flip); flip_reset = 1'b1;

    apply("init_300", 300, 1, 0, 0);
    apply("ovr1", 650, 1, 0, 0);
    apply("ovr2", 650, 1, 0, 0);
    apply("ovr3", 650, 1, 0, 0);
    repeat (5) apply("band590", 590, 1, 0, 0);
    repeat (3) apply("clear550", 550, 1, 0, 0);
    apply("chk650", 650, 1, 0, 0);
    apply("chk580", 580, 1, 0, 0);
    apply("chk650b", 650, 1, 0, 0);
    apply("back300", 300, 1, 0, 0);

    // Departure handshake.
    for (int i = 0; i < 10; i++) apply("req_held", 300, 1, 1, 1);
    apply("req_drop", 300, 1, 1, 0);
    for (int i = 0; i < 3; i++) apply("door_open", 300, 1, 0, 1);
    apply("req_drop2", 300, 1, 1, 0);
    apply("req_over", 650, 1, 1, 1);
    apply("req_after", 300, 1, 1, 1);
    apply("req_after2", 300, 1, 1, 1);

    // Watchdog expiry then recovery.
    for (int i = 0; i < TIMEOUT + 2; i++) apply("idle", 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) apply("recover300", 300, 1, 0, 0);

    // Async reset between edges while overloaded.
    repeat (3) apply("to_over", 700, 1, 0, 0);
    #2;
    flip_reset = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    @(negedge flip); flip_reset = 1'b1;

    // Randomized phase with occasional long silences.
    for (int i = 0; i < 600; i++) begin
      if (i % 150 == 149) n = TIMEOUT + $urandom_range(0, 3);
      else n = 1;
      for (int j = 0; j < n; j++) begin
        case ($urandom_range(0, 8))
          0: kg = 300;
          1: kg = 550;
          2: kg = 560;
          3: kg = 561;
          4: kg = 590;
          5: kg = 600;
          6: kg = 601;
          7: kg = 650;
          default: kg = $urandom_range(0, 1023);
        endcase
        v = (n > 1) ? 1'b0 : ($urandom_range(0, 3) != 0);
        apply("rand", kg, v, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
